iterative_shift_unit: RTL

ITERATIVE_SHIFT_UNIT -- requirements
Module: iterative_shift_unit

---
 rtl/iterative_shift_unit_if.sv | 26 ++
 rtl/iterative_shift_unit.sv | 76 +++++++
 2 files changed

// File: rtl/iterative_shift_unit_if.sv
// Request/result handshake bundle for iterative_shift_unit.
// master = requester/consumer side, slave = the shift unit.
interface iterative_shift_unit_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) ();
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_a;
  logic [SW-1:0] up_amount;
  logic          up_dir;
  logic          up_arith;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_res;

  modport master (
    output up_valid, up_a, up_amount, up_dir, up_arith, down_ready,
    input  up_ready, down_valid, down_res
  );

  modport slave (
    input  up_valid, up_a, up_amount, up_dir, up_arith, down_ready,
    output up_ready, down_valid, down_res
  );
endinterface

// File: rtl/iterative_shift_unit.sv
// One-bit-per-cycle shifter with valid/ready request and result handshakes.
// Define ITERATIVE_SHIFT_ARITH_EN to honour up_arith (sign-extending right shift).
//
// state | meaning
// IDLE  | waiting for a request, up_ready = 1
// SHIFT | shifting work one bit per edge until count reaches 0
// DONE  | result held on down_res, down_valid = 1 until consumed
module iterative_shift_unit #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  iterative_shift_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  work;
  logic [SW-1:0] count;
  logic          dir_q;
  logic          fill_msb;

`ifdef ITERATIVE_SHIFT_ARITH_EN
  logic arith_q;
  assign fill_msb = arith_q & work[N-1];
`else
  logic unused_arith;
  assign unused_arith = bus.up_arith;
  assign fill_msb     = 1'b0;
`endif

  assign bus.up_ready   = (state == IDLE);
  assign bus.down_valid = (state == DONE);
  assign bus.down_res   = work;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      count <= '0;
      dir_q <= 1'b0;
`ifdef ITERATIVE_SHIFT_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.up_valid) begin
            work  <= bus.up_a;
            count <= bus.up_amount;
            dir_q <= bus.up_dir;
`ifdef ITERATIVE_SHIFT_ARITH_EN
            arith_q <= bus.up_arith;
`endif
            state <= (bus.up_amount == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (dir_q)
            work <= {fill_msb, work[N-1:1]};
          else
            work <= {work[N-2:0], 1'b0};
          count <= count - SW'(1);
          if (count == SW'(1))
            state <= DONE;
        end
        DONE: begin
          if (bus.down_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
